// File: rtl/rv_boot_loader.sv
// rv_boot_loader: loads a framed little-endian byte image into imem/dmem, then runs the core until halt or timeout.
// Build option LOADER_CHECKSUM_EN adds a one-byte trailer checksum (CSUM state, err flag).
//
// state  | meaning
// IDLE   | waiting for start, core held in reset
// HDR    | collecting the 4-byte word count
// LOAD   | collecting payload words and issuing memory writes
// CSUM   | collecting the trailer byte (checksum build only)
// RUN    | core released, cycle counter running
// DONE   | finished (done/timeout/err), core held in reset

module rv_boot_loader #(
   parameter int          ADDR_BITS      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic                 start,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 imem_we,
   output logic [ADDR_BITS-1:0] imem_waddr,
   output logic [31:0]          imem_wdata,
   input  logic                 core_dmem_we,
   input  logic [ADDR_BITS-1:0] core_dmem_waddr,
   input  logic [31:0]          core_dmem_wdata,
   output logic                 dmem_we,
   output logic [ADDR_BITS-1:0] dmem_waddr,
   output logic [31:0]          dmem_wdata,
   input  logic                 core_halt,
   output logic                 core_reset,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic                 err,
   output logic [31:0]          cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LOAD,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_RUN,
      S_DONE
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_POST = S_CSUM;
`else
   localparam state_t S_POST = S_RUN;
`endif

   state_t               state_q, state_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [31:0]          word_q, word_d;
   logic [31:0]          n_q, n_d;
   logic [31:0]          k_q, k_d;
   logic                 imem_we_q, imem_we_d;
   logic [ADDR_BITS-1:0] imem_waddr_q, imem_waddr_d;
   logic [31:0]          imem_wdata_q, imem_wdata_d;
   logic                 ld_dmem_we_q, ld_dmem_we_d;
   logic [ADDR_BITS-1:0] ld_dmem_waddr_q, ld_dmem_waddr_d;
   logic [31:0]          ld_dmem_wdata_q, ld_dmem_wdata_d;
   logic                 done_q, done_d;
   logic                 timeout_q, timeout_d;
   logic [31:0]          cycles_q, cycles_d;
   logic                 core_reset_q, core_reset_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]           csum_q, csum_d;
   logic                 err_q, err_d;
`endif

   logic        accept;
   logic [31:0] asm_word;
   logic [31:0] k_hi;
   logic        sel_core;

   assign rx_ready = (state_q == S_HDR) || (state_q == S_LOAD)
`ifdef LOADER_CHECKSUM_EN
                     || (state_q == S_CSUM)
`endif
                     ;
   assign accept   = rx_valid && rx_ready;
   assign asm_word = {rx_data, word_q[31:8]};
   assign k_hi     = k_q >> (ADDR_BITS + 1);

   always_comb begin
      state_d         = state_q;
      byte_cnt_d      = byte_cnt_q;
      word_d          = word_q;
      n_d             = n_q;
      k_d             = k_q;
      imem_we_d       = 1'b0;
      imem_waddr_d    = imem_waddr_q;
      imem_wdata_d    = imem_wdata_q;
      ld_dmem_we_d    = 1'b0;
      ld_dmem_waddr_d = ld_dmem_waddr_q;
      ld_dmem_wdata_d = ld_dmem_wdata_q;
      done_d          = done_q;
      timeout_d       = timeout_q;
      cycles_d        = cycles_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d          = csum_q;
      err_d           = err_q;
      if (accept && (state_q == S_HDR || state_q == S_LOAD))
         csum_d = csum_q + rx_data;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_HDR;
               byte_cnt_d = 2'd0;
               word_d     = 32'd0;
               k_d        = 32'd0;
               done_d     = 1'b0;
               timeout_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               csum_d     = 8'd0;
               err_d      = 1'b0;
`endif
            end
         end
         S_HDR: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               word_d     = asm_word;
               if (byte_cnt_q == 2'd3) begin
                  n_d     = asm_word;
                  state_d = (asm_word == 32'd0) ? S_POST : S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               word_d     = asm_word;
               if (byte_cnt_q == 2'd3) begin
                  // Words beyond the dmem window are consumed silently.
                  if (k_hi == 32'd0) begin
                     if (k_q[ADDR_BITS]) begin
                        ld_dmem_we_d    = 1'b1;
                        ld_dmem_waddr_d = k_q[ADDR_BITS-1:0];
                        ld_dmem_wdata_d = asm_word;
                     end else begin
                        imem_we_d    = 1'b1;
                        imem_waddr_d = k_q[ADDR_BITS-1:0];
                        imem_wdata_d = asm_word;
                     end
                  end
                  k_d = k_q + 32'd1;
                  if (k_q == n_q - 32'd1)
                     state_d = S_POST;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               if (8'(csum_q + rx_data) == 8'd0) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         S_RUN: begin
            if (core_halt) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && cycles_q == 32'(TIMEOUT_CYCLES)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else if (cycles_q != 32'hFFFF_FFFF) begin
               cycles_d = cycles_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_RUN && state_q != S_RUN)
         cycles_d = 32'd0;
      // Release lags RUN entry by one cycle so the final write lands first.
      core_reset_d = !(state_q == S_RUN && state_d == S_RUN);
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state_q         <= S_IDLE;
         byte_cnt_q      <= 2'd0;
         word_q          <= 32'd0;
         n_q             <= 32'd0;
         k_q             <= 32'd0;
         imem_we_q       <= 1'b0;
         imem_waddr_q    <= '0;
         imem_wdata_q    <= 32'd0;
         ld_dmem_we_q    <= 1'b0;
         ld_dmem_waddr_q <= '0;
         ld_dmem_wdata_q <= 32'd0;
         done_q          <= 1'b0;
         timeout_q       <= 1'b0;
         cycles_q        <= 32'd0;
         core_reset_q    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         csum_q          <= 8'd0;
         err_q           <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         byte_cnt_q      <= byte_cnt_d;
         word_q          <= word_d;
         n_q             <= n_d;
         k_q             <= k_d;
         imem_we_q       <= imem_we_d;
         imem_waddr_q    <= imem_waddr_d;
         imem_wdata_q    <= imem_wdata_d;
         ld_dmem_we_q    <= ld_dmem_we_d;
         ld_dmem_waddr_q <= ld_dmem_waddr_d;
         ld_dmem_wdata_q <= ld_dmem_wdata_d;
         done_q          <= done_d;
         timeout_q       <= timeout_d;
         cycles_q        <= cycles_d;
         core_reset_q    <= core_reset_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q          <= csum_d;
         err_q           <= err_d;
`endif
      end
   end

   // The core owns dmem only once it is actually out of reset.
   assign sel_core   = (state_q == S_RUN) && !core_reset_q;
   assign dmem_we    = sel_core ? core_dmem_we    : ld_dmem_we_q;
   assign dmem_waddr = sel_core ? core_dmem_waddr : ld_dmem_waddr_q;
   assign dmem_wdata = sel_core ? core_dmem_wdata : ld_dmem_wdata_q;

   assign imem_we    = imem_we_q;
   assign imem_waddr = imem_waddr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_reset = core_reset_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign cycles     = cycles_q;
`ifdef LOADER_CHECKSUM_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_rv_boot_loader.sv
// Directed testbench for rv_boot_loader with a small memory size (ADDR_BITS=4) and TIMEOUT_CYCLES=150.
// Honours LOADER_CHECKSUM_EN by appending trailer bytes and running the checksum scenario.
`timescale 1ns/1ps
module tb_rv_boot_loader;
   localparam int AB = 4;
   localparam int TO = 150;

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b0;
   logic          start = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_ready;
   logic          imem_we;
   logic [AB-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          core_dmem_we = 1'b0;
   logic [AB-1:0] core_dmem_waddr = '0;
   logic [31:0]   core_dmem_wdata = 32'd0;
   logic          dmem_we;
   logic [AB-1:0] dmem_waddr;
   logic [31:0]   dmem_wdata;
   logic          core_halt = 1'b0;
   logic          core_reset, busy, done, timeout, err;
   logic [31:0]   cycles;

   int checks = 0;
   int failures = 0;
   int imem_cnt = 0;
   int dmem_cnt = 0;
   logic [31:0] imem_mem [0:15];
   logic [31:0] dmem_mem [0:15];
   logic [7:0]  tb_sum = 8'd0;

   rv_boot_loader #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .core_dmem_we(core_dmem_we), .core_dmem_waddr(core_dmem_waddr), .core_dmem_wdata(core_dmem_wdata),
      .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .core_halt(core_halt),
      .core_reset(core_reset), .busy(busy), .done(done), .timeout(timeout), .err(err), .cycles(cycles));

   always #5 CLOCK = ~CLOCK;

   always @(negedge CLOCK) begin
      if (imem_we === 1'b1) begin imem_cnt++; imem_mem[imem_waddr] = imem_wdata; end
      if (dmem_we === 1'b1) begin dmem_cnt++; dmem_mem[dmem_waddr] = dmem_wdata; end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin @(posedge CLOCK); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1; tb_sum = 8'd0; tick(); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b; tb_sum = tb_sum + b; tick(); rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic finish_frame();
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] t;
      t = 8'd0 - tb_sum;
      send_byte(t);
`endif
   endtask

   task automatic test_reset();
      RESET = 1'b0; tick(3);
      checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
      checks++; if ({imem_we, dmem_we} !== 2'b00) begin failures++; $display("FAIL reset_we got=%b exp=00", {imem_we, dmem_we}); end
      checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
      checks++; if ({busy, done, timeout, err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, timeout, err}); end
      checks++; if (cycles !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%h exp=0", cycles); end
      checks++; if ({imem_waddr, imem_wdata, dmem_waddr, dmem_wdata} !== '0) begin failures++; $display("FAIL reset_addr_data got=%h/%h/%h/%h exp=0", imem_waddr, imem_wdata, dmem_waddr, dmem_wdata); end
      RESET = 1'b1; tick();
   endtask

   task automatic test_dmem_blocked_idle();
      core_dmem_we = 1'b1; core_dmem_waddr = 4'd5; core_dmem_wdata = 32'h12345678; #1;
      checks++; if (dmem_we !== 1'b0 || dmem_waddr !== 4'd0) begin failures++; $display("FAIL idle_dmem_block got=%b/%h exp=0/0", dmem_we, dmem_waddr); end
      core_dmem_we = 1'b0; core_dmem_waddr = '0; core_dmem_wdata = 32'd0;
      tick();
   endtask

   task automatic test_imem_load_and_halt();
      int base;
      base = imem_cnt;
      pulse_start();
      checks++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin failures++; $display("FAIL start_hdr got=%b%b exp=11", busy, rx_ready); end
      send_word(32'd2);
      send_word(32'h00000513);
      checks++; if (imem_we !== 1'b1 || imem_waddr !== 4'd0 || imem_wdata !== 32'h00000513) begin failures++; $display("FAIL imem_w0 got=%b/%h/%h exp=1/0/00000513", imem_we, imem_waddr, imem_wdata); end
      send_word(32'h00100073);
      checks++; if (imem_we !== 1'b1 || imem_waddr !== 4'd1 || imem_wdata !== 32'h00100073) begin failures++; $display("FAIL imem_w1 got=%b/%h/%h exp=1/1/00100073", imem_we, imem_waddr, imem_wdata); end
      finish_frame();
      checks++; if (core_reset !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL run_entry got=%b%b%b exp=101", core_reset, rx_ready, busy); end
      tick();
      checks++; if (core_reset !== 1'b0 || imem_we !== 1'b0) begin failures++; $display("FAIL release got=%b/%b exp=0/0", core_reset, imem_we); end
      checks++; if (imem_cnt - base !== 2) begin failures++; $display("FAIL imem_strobes got=%0d exp=2", imem_cnt - base); end
      core_dmem_we = 1'b1; core_dmem_waddr = 4'd5; core_dmem_wdata = 32'h12345678; #1;
      checks++; if (dmem_we !== 1'b1 || dmem_waddr !== 4'd5 || dmem_wdata !== 32'h12345678) begin failures++; $display("FAIL dmem_pass got=%b/%h/%h exp=1/5/12345678", dmem_we, dmem_waddr, dmem_wdata); end
      core_dmem_we = 1'b0; core_dmem_waddr = '0; core_dmem_wdata = 32'd0;
      tick(99);
      core_halt = 1'b1; tick(); core_halt = 1'b0;
      checks++; if (done !== 1'b1 || timeout !== 1'b0 || cycles !== 32'd100) begin failures++; $display("FAIL halt got=%b/%b/%0d exp=1/0/100", done, timeout, cycles); end
      checks++; if (core_reset !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL halt_state got=%b/%b exp=1/0", core_reset, busy); end
      tick(3);
      checks++; if (cycles !== 32'd100) begin failures++; $display("FAIL cycles_frozen got=%0d exp=100", cycles); end
   endtask

   task automatic test_dmem_window_and_timeout();
      int ib, db;
      ib = imem_cnt; db = dmem_cnt;
      pulse_start();
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL restart_clear got=%b/%b exp=0/1", done, busy); end
      send_word(32'd34);
      for (int k = 0; k < 34; k++) send_word(k == 16 ? 32'hDEADBEEF : 32'h10000000 + k);
      finish_frame();
      checks++; if (imem_cnt - ib !== 16 || dmem_cnt - db !== 16) begin failures++; $display("FAIL window_counts got=%0d/%0d exp=16/16", imem_cnt - ib, dmem_cnt - db); end
      checks++; if (dmem_mem[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL dmem0 got=%h exp=deadbeef", dmem_mem[0]); end
      checks++; if (dmem_mem[15] !== 32'h1000001F || imem_mem[15] !== 32'h1000000F) begin failures++; $display("FAIL window_ends got=%h/%h exp=1000001f/1000000f", dmem_mem[15], imem_mem[15]); end
      checks++; if (imem_mem[0] !== 32'h10000000 || imem_mem[1] !== 32'h10000001) begin failures++; $display("FAIL no_alias got=%h/%h exp=10000000/10000001", imem_mem[0], imem_mem[1]); end
      tick(150);
      checks++; if (timeout !== 1'b0 || cycles !== 32'd150) begin failures++; $display("FAIL pre_timeout got=%b/%0d exp=0/150", timeout, cycles); end
      tick();
      checks++; if (timeout !== 1'b1 || done !== 1'b0 || cycles !== 32'd150 || core_reset !== 1'b1) begin failures++; $display("FAIL timeout got=%b/%b/%0d/%b exp=1/0/150/1", timeout, done, cycles, core_reset); end
   endtask

   task automatic test_zero_len_tie();
      pulse_start();
      send_word(32'd0);
      finish_frame();
      checks++; if (busy !== 1'b1 || rx_ready !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL zero_len_run got=%b/%b/%b exp=1/0/0", busy, rx_ready, timeout); end
      tick(150);
      core_halt = 1'b1; tick(); core_halt = 1'b0;
      checks++; if (done !== 1'b1 || timeout !== 1'b0 || cycles !== 32'd150) begin failures++; $display("FAIL halt_wins got=%b/%b/%0d exp=1/0/150", done, timeout, cycles); end
   endtask

   task automatic test_reset_mid_load();
      int base;
      pulse_start();
      send_word(32'd3);
      base = imem_cnt;
      send_word(32'h11223344);
      send_byte(8'hAA); send_byte(8'hBB);
      RESET = 1'b0; rx_valid = 1'b1; rx_data = 8'hCC; tick();
      checks++; if (busy !== 1'b0 || rx_ready !== 1'b0 || core_reset !== 1'b1 || imem_we !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b%b%b%b exp=0010", busy, rx_ready, core_reset, imem_we); end
      RESET = 1'b1; rx_valid = 1'b1; rx_data = 8'hDD; tick(6); rx_valid = 1'b0; tick();
      checks++; if (imem_cnt - base !== 1 || imem_mem[0] !== 32'h11223344) begin failures++; $display("FAIL mid_reset_writes got=%0d/%h exp=1/11223344", imem_cnt - base, imem_mem[0]); end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      pulse_start();
      send_word(32'd1);
      send_word(32'h00000513);
      send_byte(8'h00);
      checks++; if (err !== 1'b1 || busy !== 1'b0 || core_reset !== 1'b1) begin failures++; $display("FAIL csum_bad got=%b/%b/%b exp=1/0/1", err, busy, core_reset); end
      tick(3);
      checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL csum_bad_hold got=%b exp=1", core_reset); end
      pulse_start();
      send_word(32'd1);
      send_word(32'h00000513);
      send_byte(8'hE7);
      tick();
      checks++; if (err !== 1'b0 || busy !== 1'b1 || core_reset !== 1'b0) begin failures++; $display("FAIL csum_good got=%b/%b/%b exp=0/1/0", err, busy, core_reset); end
      RESET = 1'b0; tick(); RESET = 1'b1; tick();
   endtask
`endif

   initial begin
      test_reset();
      test_dmem_blocked_idle();
      test_imem_load_and_halt();
      test_dmem_window_and_timeout();
      test_zero_len_tie();
      test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rv_boot_loader.md
# rv_boot_loader

Byte-stream program loader that sits directly upstream of the `computer` core. It receives a framed little-endian image over a valid/ready byte interface and writes it into the instruction and data memories. The image uses the combined layout: word index 0..2^ADDR_BITS-1 goes to imem, the next 2^ADDR_BITS words go to dmem. It then releases the core from reset, owns the dmem write port until release, counts cycles until `computer_ret`, and reports completion or timeout.

## Interface
- ADDR_BITS, 16, word-address width of each memory (imem and dmem each hold 2^ADDR_BITS words)
- TIMEOUT_CYCLES, 50000, run-phase cycle limit; 0 disables the timeout
- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when in IDLE or DONE
- rx_valid  in  1  byte available
- rx_data  in  8  byte payload
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid && rx_ready
- imem_we  out  1  imem write strobe
- imem_waddr  out  ADDR_BITS  imem word address
- imem_wdata  out  32  imem write data
- core_dmem_we  in  1  core dmem write strobe (from dmem_arg_MEMB32W65536_WE2)
- core_dmem_waddr  in  ADDR_BITS  core dmem write address
- core_dmem_wdata  in  32  core dmem write data
- dmem_we  out  1  muxed dmem write strobe to RAM
- dmem_waddr  out  ADDR_BITS  muxed dmem write address
- dmem_wdata  out  32  muxed dmem write data
- core_halt  in  1  core `computer_ret`
- core_reset  out  1  active-high reset to core RESET
- busy  out  1  state is HDR, LOAD, CSUM or RUN
- done  out  1  core halted within the limit; held until next start
- timeout  out  1  run limit reached; held until next start
- err  out  1  checksum mismatch (CSUM build only); held until next start
- cycles  out  32  run-phase cycle count, saturating at 0xFFFFFFFF

## Operation
- States: IDLE, HDR, LOAD, CSUM (CSUM build only), RUN, DONE.
- **IDLE/DONE:** start → HDR. The byte counter, word index, checksum and flags clear. cycles clears on entry to RUN.
- **HDR:** accepts 4 bytes, little-endian, forming 32-bit word count N.
  - N == 0 → CSUM, or RUN when CSUM is compiled out.
  - Otherwise → LOAD.
- **LOAD:** bytes assemble LSB-first into a word.
  - On acceptance of byte 3 of word k, a write to index k is registered.
    - k < 2^ADDR_BITS: imem[k].
    - 2^ADDR_BITS ≤ k < 2^(ADDR_BITS+1): dmem[k - 2^ADDR_BITS].
    - k ≥ 2^(ADDR_BITS+1): bytes are consumed and no write is issued.
  - After word N-1 → CSUM, or RUN when CSUM is compiled out.
- **RUN:** core_reset = 0. cycles increments every cycle.
  - core_halt = 1 → DONE with done = 1.
  - cycles == TIMEOUT_CYCLES (nonzero) → DONE with timeout = 1.
  - Halt and limit in the same cycle: done wins.
- **DONE:** core_reset = 1. The count freezes.
- **dmem mux:** in RUN, core_dmem_* passes through combinationally. In all other states the loader drives the dmem outputs, so core_dmem_we has no effect.
- start while busy is ignored. rx_ready = 0 outside HDR, LOAD and CSUM.

## Timing
- Reset values: all state is IDLE.
  - rx_ready = 0, imem_we = 0, dmem_we = 0.
  - core_reset = 1.
  - busy, done, timeout, err = 0; cycles = 0.
  - Write addresses and data = 0.
- start sampled at cycle t → HDR at t+1, with rx_ready = 1 from t+1.
- rx_ready stays high continuously through HDR and LOAD. Write ports are dedicated, so there is no backpressure.
- A write strobe is high for exactly one cycle, the cycle after byte 3 is accepted. Address and data are valid in that same cycle.
- The last write and the state change to RUN occur in the same cycle. core_reset falls one cycle after that, so the final write lands before the core fetches.
- RESET low mid-load or mid-run: returns to IDLE the next edge.
  - core_reset reasserts.
  - Partially assembled words are discarded and no partial write is issued.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last word, CSUM accepts one byte.
  - The 8-bit modular sum of all header and payload bytes plus this byte must equal 0x00.
  - Match → RUN.
  - Mismatch → DONE with err = 1; the core is never released from reset.
- LOADER_CHECKSUM_EN undefined:
  - CSUM state, checksum register and err logic are absent. err is tied 0.
  - The frame ends after the last payload byte.

## Test plan
- Header N=2, then bytes 13 05 00 00 / 73 00 10 00 → imem[0]=0x00000513 and imem[1]=0x00100073, one write strobe each, core_reset falls one cycle after the second write.
- N=65537, with word 65536 = 0xDEADBEEF → imem_we never fires for it; dmem_we fires with dmem_waddr=0 and dmem_wdata=0xDEADBEEF.
- After release, core drives core_dmem_we=1, waddr=5, wdata=0x12345678 → dmem outputs mirror it the same cycle. The same stimulus in IDLE is blocked (dmem_we=0).
- core_halt pulses 100 cycles after release → done=1, cycles=100, core_reset=1. A further start clears done.
- Core never halts, TIMEOUT_CYCLES=50 → timeout=1 at cycles=50. Separately, RESET low for one cycle during LOAD → IDLE, no further writes.
- With LOADER_CHECKSUM_EN, N=1 and a wrong trailer byte → err=1, core_reset stays 1. With the correct trailer → RUN.
